// File: rtl/wdg_win_core_if.sv
// Register-file side of the windowed watchdog: config/key/clear strobes in,
// counter, flags and reset request out.
interface wdg_win_core_if #(
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned PSCR_WIDTH = 20
);
  logic                  cfg_we_i;
  logic                  cfg_en_i;
  logic [PSCR_WIDTH-1:0] cfg_pscr_i;
  logic [CNT_WIDTH-1:0]  cfg_cmp_i;
  logic [CNT_WIDTH-1:0]  cfg_win_i;
  logic [CNT_WIDTH-1:0]  cfg_ew_i;
  logic                  key_we_i;
  logic [31:0]           key_i;
  logic [2:0]            flag_clr_i;
  logic [CNT_WIDTH-1:0]  cnt_o;
  logic                  ovif_o;
  logic                  ewif_o;
  logic                  werr_o;
  logic                  irq_o;
  logic                  locked_o;
  logic                  rst_o;
  logic [1:0]            state_o;

  modport master (
    output cfg_we_i, cfg_en_i, cfg_pscr_i, cfg_cmp_i, cfg_win_i, cfg_ew_i,
           key_we_i, key_i, flag_clr_i,
    input  cnt_o, ovif_o, ewif_o, werr_o, irq_o, locked_o, rst_o, state_o
  );

  modport slave (
    input  cfg_we_i, cfg_en_i, cfg_pscr_i, cfg_cmp_i, cfg_win_i, cfg_ew_i,
           key_we_i, key_i, flag_clr_i,
    output cnt_o, ovif_o, ewif_o, werr_o, irq_o, locked_o, rst_o, state_o
  );
endinterface

// File: rtl/wdg_win_core.sv
// Windowed watchdog: prescaled counter with refresh window, early warning,
// key-protected configuration lock and a stretched reset pulse.
module wdg_win_core #(
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned PSCR_WIDTH = 20,
  parameter logic [31:0] FEED_KEY   = 32'h5A5A_A5A5,
  parameter logic [31:0] UNLOCK_KEY = 32'h1ACC_E551,
  parameter int unsigned RST_LEN    = 16,
  parameter bit          STRICT_KEY = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  wdg_win_core_if.slave  bus
);

  localparam int unsigned PLEN_W = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
  localparam logic [PLEN_W-1:0]     PLEN_LAST = PLEN_W'(RST_LEN - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
  localparam logic [PSCR_WIDTH-1:0] PSCR_RST  = PSCR_WIDTH'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RST  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  en_q, en_d;
  logic [PSCR_WIDTH-1:0] pscr_q, pscr_d;
  logic [PSCR_WIDTH-1:0] pscr_act_q, pscr_act_d;
  logic [CNT_WIDTH-1:0]  cmp_q, cmp_d;
  logic [CNT_WIDTH-1:0]  win_q, win_d;
  logic [CNT_WIDTH-1:0]  ew_q, ew_d;
  logic [PSCR_WIDTH-1:0] psc_q, psc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ovif_q, ovif_d;
  logic                  ewif_q, ewif_d;
  logic                  werr_q, werr_d;
  logic                  unlock_q, unlock_d;
  logic                  locked_q, locked_d;
  logic                  rst_q, rst_d;
  logic [PLEN_W-1:0]     pcnt_q, pcnt_d;

  logic                  ov_set, ew_set, werr_set;
  logic [PSCR_WIDTH-1:0] psc_last;
  logic                  tick, timeout, ew_hit;
  logic                  key_feed, key_unl, key_bad, win_ok, cfg_acc;

  // Divider below 2 is treated as 2; the active divider only changes on a wrap.
  assign psc_last = (pscr_act_q < PSCR_RST) ? PSCR_WIDTH'(1) : pscr_act_q - PSCR_WIDTH'(1);
  assign tick     = (state_q == RUN) && (psc_q == psc_last);
  assign timeout  = tick && ((cmp_q == '0) || (cnt_q == cmp_q - CNT_WIDTH'(1)));
  assign ew_hit   = tick && (ew_q != '0) && (cnt_q == ew_q - CNT_WIDTH'(1));

  assign key_feed = bus.key_we_i && (bus.key_i == FEED_KEY);
  assign key_unl  = bus.key_we_i && (bus.key_i == UNLOCK_KEY) && !key_feed;
  assign key_bad  = bus.key_we_i && STRICT_KEY && (bus.key_i != FEED_KEY)
                    && (bus.key_i != UNLOCK_KEY);
  assign win_ok   = (cnt_q >= win_q);
  assign cfg_acc  = bus.cfg_we_i && ((state_q == IDLE) || ((state_q == RUN) && unlock_q));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      pscr_q     <= PSCR_RST;
      pscr_act_q <= PSCR_RST;
      cmp_q      <= '0;
      win_q      <= '0;
      ew_q       <= '0;
      psc_q      <= '0;
      cnt_q      <= '0;
      ovif_q     <= 1'b0;
      ewif_q     <= 1'b0;
      werr_q     <= 1'b0;
      unlock_q   <= 1'b0;
      locked_q   <= 1'b0;
      rst_q      <= 1'b0;
      pcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      pscr_q     <= pscr_d;
      pscr_act_q <= pscr_act_d;
      cmp_q      <= cmp_d;
      win_q      <= win_d;
      ew_q       <= ew_d;
      psc_q      <= psc_d;
      cnt_q      <= cnt_d;
      ovif_q     <= ovif_d;
      ewif_q     <= ewif_d;
      werr_q     <= werr_d;
      unlock_q   <= unlock_d;
      locked_q   <= locked_d;
      rst_q      <= rst_d;
      pcnt_q     <= pcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    pscr_d     = pscr_q;
    pscr_act_d = pscr_act_q;
    cmp_d      = cmp_q;
    win_d      = win_q;
    ew_d       = ew_q;
    psc_d      = psc_q;
    cnt_d      = cnt_q;
    unlock_d   = unlock_q;
    pcnt_d     = pcnt_q;
    ov_set     = 1'b0;
    ew_set     = 1'b0;
    werr_set   = 1'b0;

    if (cfg_acc) begin
      en_d     = bus.cfg_en_i;
      pscr_d   = bus.cfg_pscr_i;
      cmp_d    = bus.cfg_cmp_i;
      win_d    = bus.cfg_win_i;
      ew_d     = bus.cfg_ew_i;
      unlock_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d      = '0;
        psc_d      = '0;
        pscr_act_d = pscr_q;
        if (en_q) state_d = RUN;
      end
      RUN: begin
        if (!en_q) begin
          state_d  = IDLE;
          cnt_d    = '0;
          psc_d    = '0;
          unlock_d = 1'b0;
        end else begin
          psc_d = tick ? '0 : psc_q + PSCR_WIDTH'(1);
          if (tick) pscr_act_d = pscr_q;
          if (tick && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_WIDTH'(1);
          // A valid feed supersedes everything the tick would have done.
          if (key_feed && win_ok) begin
            cnt_d    = '0;
            psc_d    = '0;
            unlock_d = 1'b0;
          end else begin
            ew_set   = ew_hit;
            ov_set   = timeout;
            werr_set = (key_feed && !win_ok) || key_bad;
            if (key_unl) unlock_d = 1'b1;
            if (ov_set || werr_set) begin
              state_d  = RST;
              cnt_d    = '0;
              psc_d    = '0;
              unlock_d = 1'b0;
              pcnt_d   = '0;
            end
          end
        end
      end
      RST: begin
        cnt_d      = '0;
        psc_d      = '0;
        pscr_act_d = pscr_q;
        if (pcnt_q == PLEN_LAST) begin
          state_d = en_q ? RUN : IDLE;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + PLEN_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        psc_d   = '0;
      end
    endcase

    // Set wins over a concurrent write-1-clear.
    ovif_d   = (ovif_q & ~bus.flag_clr_i[0]) | ov_set;
    ewif_d   = (ewif_q & ~bus.flag_clr_i[1]) | ew_set;
    werr_d   = (werr_q & ~bus.flag_clr_i[2]) | werr_set;
    rst_d    = (state_d == RST);
    locked_d = (state_d == RUN) && !unlock_d;
  end

  assign bus.cnt_o    = cnt_q;
  assign bus.ovif_o   = ovif_q;
  assign bus.ewif_o   = ewif_q;
  assign bus.werr_o   = werr_q;
  assign bus.irq_o    = ewif_q;
  assign bus.locked_o = locked_q;
  assign bus.rst_o    = rst_q;
  assign bus.state_o  = state_q;

endmodule

// File: tb/tb_wdg_win_core.sv
// Directed bench for wdg_win_core: a strict-key instance plus a non-strict
// twin fed the same stimulus.
module tb_wdg_win_core;

  localparam logic [31:0] FEED = 32'h5A5A_A5A5;
  localparam logic [31:0] UNL  = 32'h1ACC_E551;
  localparam logic [31:0] BAD  = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  wdg_win_core_if #(.CNT_WIDTH(32), .PSCR_WIDTH(20)) bus ();
  wdg_win_core_if #(.CNT_WIDTH(32), .PSCR_WIDTH(20)) bus_ns ();

  assign bus_ns.cfg_we_i   = bus.cfg_we_i;
  assign bus_ns.cfg_en_i   = bus.cfg_en_i;
  assign bus_ns.cfg_pscr_i = bus.cfg_pscr_i;
  assign bus_ns.cfg_cmp_i  = bus.cfg_cmp_i;
  assign bus_ns.cfg_win_i  = bus.cfg_win_i;
  assign bus_ns.cfg_ew_i   = bus.cfg_ew_i;
  assign bus_ns.key_we_i   = bus.key_we_i;
  assign bus_ns.key_i      = bus.key_i;
  assign bus_ns.flag_clr_i = bus.flag_clr_i;

  wdg_win_core #(.STRICT_KEY(1'b1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  wdg_win_core #(.STRICT_KEY(1'b0)) dut_ns (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_ns)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic cfg(input logic en, input logic [19:0] pscr,
                     input logic [31:0] cmp, input logic [31:0] win, input logic [31:0] ew);
    bus.cfg_en_i   = en;
    bus.cfg_pscr_i = pscr;
    bus.cfg_cmp_i  = cmp;
    bus.cfg_win_i  = win;
    bus.cfg_ew_i   = ew;
    bus.cfg_we_i   = 1'b1;
    step();
    bus.cfg_we_i   = 1'b0;
  endtask

  task automatic key(input logic [31:0] k);
    bus.key_i    = k;
    bus.key_we_i = 1'b1;
    step();
    bus.key_we_i = 1'b0;
  endtask

  task automatic clr(input logic [2:0] c);
    bus.flag_clr_i = c;
    step();
    bus.flag_clr_i = 3'b000;
  endtask

  // Called with rst_o already high for one sampled cycle; counts the pulse.
  task automatic pulse_len(input string tag);
    int n = 1;
    for (int i = 0; i < 64; i++) begin
      step();
      if (bus.rst_o) n++;
      else break;
    end
    chk(tag, 32'(n), 32'd16);
  endtask

  initial begin
    bus.cfg_we_i   = 1'b0;
    bus.cfg_en_i   = 1'b0;
    bus.cfg_pscr_i = '0;
    bus.cfg_cmp_i  = '0;
    bus.cfg_win_i  = '0;
    bus.cfg_ew_i   = '0;
    bus.key_we_i   = 1'b0;
    bus.key_i      = '0;
    bus.flag_clr_i = 3'b000;

    // Reset state
    do_reset();
    chk("rst_state",  32'(bus.state_o), 32'd0);
    chk("rst_cnt",    bus.cnt_o, 32'd0);
    chk("rst_flags",  32'({bus.werr_o, bus.ewif_o, bus.ovif_o}), 32'd0);
    chk("rst_rsto",   32'(bus.rst_o), 32'd0);
    chk("rst_locked", 32'(bus.locked_o), 32'd0);

    // Basic timeout: P=2, cmp=5 -> timeout on the 10th RUN edge
    cfg(1'b1, 20'd2, 32'd5, 32'd0, 32'd0);
    chk("idle_after_cfg", 32'(bus.state_o), 32'd0);
    step();
    chk("run_entry", 32'(bus.state_o), 32'd1);
    chk("run_locked", 32'(bus.locked_o), 32'd1);
    step(9);
    chk("to_cnt4", bus.cnt_o, 32'd4);
    chk("to_no_ovif_yet", 32'(bus.ovif_o), 32'd0);
    step();
    chk("to_ovif", 32'(bus.ovif_o), 32'd1);
    chk("to_rsto", 32'(bus.rst_o), 32'd1);
    chk("to_state_rst", 32'(bus.state_o), 32'd2);
    chk("to_cnt0", bus.cnt_o, 32'd0);
    pulse_len("to_pulse_len");
    chk("to_back_run", 32'(bus.state_o), 32'd1);
    chk("to_cnt_after", bus.cnt_o, 32'd0);
    chk("to_ovif_sticky", 32'(bus.ovif_o), 32'd1);
    clr(3'b111);
    chk("to_ovif_clr", 32'(bus.ovif_o), 32'd0);

    // Window violation: feed at cnt=2 with win=4
    do_reset();
    cfg(1'b1, 20'd2, 32'd10, 32'd4, 32'd0);
    step(5);
    chk("win_cnt2", bus.cnt_o, 32'd2);
    key(FEED);
    chk("win_werr", 32'(bus.werr_o), 32'd1);
    chk("win_rsto", 32'(bus.rst_o), 32'd1);
    pulse_len("win_pulse_len");

    // Valid feed at cnt=5
    do_reset();
    cfg(1'b1, 20'd2, 32'd10, 32'd4, 32'd0);
    step(11);
    chk("feed_cnt5", bus.cnt_o, 32'd5);
    key(FEED);
    chk("feed_cnt0", bus.cnt_o, 32'd0);
    chk("feed_flags", 32'({bus.werr_o, bus.ewif_o, bus.ovif_o}), 32'd0);
    chk("feed_rsto", 32'(bus.rst_o), 32'd0);
    chk("feed_state", 32'(bus.state_o), 32'd1);

    // Early warning at cnt 2->3, clear, then set-wins-over-clear
    do_reset();
    cfg(1'b1, 20'd2, 32'd8, 32'd0, 32'd3);
    step(6);
    chk("ew_cnt2", bus.cnt_o, 32'd2);
    chk("ew_not_yet", 32'(bus.ewif_o), 32'd0);
    step();
    chk("ew_cnt3", bus.cnt_o, 32'd3);
    chk("ew_set", 32'(bus.ewif_o), 32'd1);
    chk("ew_irq", 32'(bus.irq_o), 32'd1);
    clr(3'b010);
    chk("ew_clr", 32'(bus.ewif_o), 32'd0);
    chk("ew_irq_clr", 32'(bus.irq_o), 32'd0);
    key(FEED);
    chk("ew_feed_cnt0", bus.cnt_o, 32'd0);
    step(5);
    chk("ew_cnt2_again", bus.cnt_o, 32'd2);
    clr(3'b010);
    chk("ew_set_wins", 32'(bus.ewif_o), 32'd1);

    // Lock: locked write ignored, unlock then disable
    cfg(1'b0, 20'd2, 32'd99, 32'd0, 32'd0);
    step(2);
    chk("lock_ignored", 32'(bus.state_o), 32'd1);
    chk("lock_locked", 32'(bus.locked_o), 32'd1);
    key(UNL);
    chk("unlock_open", 32'(bus.locked_o), 32'd0);
    cfg(1'b0, 20'd2, 32'd99, 32'd0, 32'd0);
    step();
    chk("unlock_idle", 32'(bus.state_o), 32'd0);
    chk("unlock_unlocked", 32'(bus.locked_o), 32'd0);
    chk("unlock_cnt0", bus.cnt_o, 32'd0);

    // Strict vs non-strict bad key
    do_reset();
    cfg(1'b1, 20'd2, 32'd10, 32'd0, 32'd0);
    step();
    key(BAD);
    chk("strict_werr", 32'(bus.werr_o), 32'd1);
    chk("strict_rsto", 32'(bus.rst_o), 32'd1);
    chk("lax_werr", 32'(bus_ns.werr_o), 32'd0);
    chk("lax_state", 32'(bus_ns.state_o), 32'd1);
    chk("lax_rsto", 32'(bus_ns.rst_o), 32'd0);
    pulse_len("strict_pulse_len");

    // cmp=0: timeout on first tick
    do_reset();
    cfg(1'b1, 20'd2, 32'd0, 32'd0, 32'd0);
    step(2);
    chk("cmp0_run", 32'(bus.state_o), 32'd1);
    step();
    chk("cmp0_ovif", 32'(bus.ovif_o), 32'd1);
    chk("cmp0_state", 32'(bus.state_o), 32'd2);

    // P=3, cmp=2: ticks every third cycle
    do_reset();
    cfg(1'b1, 20'd3, 32'd2, 32'd0, 32'd0);
    step(3);
    chk("p3_cnt0", bus.cnt_o, 32'd0);
    step();
    chk("p3_cnt1", bus.cnt_o, 32'd1);
    step(2);
    chk("p3_still_run", 32'(bus.state_o), 32'd1);
    step();
    chk("p3_timeout", 32'(bus.state_o), 32'd2);

    // Violation on the timeout tick: both flags, single reset entry
    do_reset();
    cfg(1'b1, 20'd2, 32'd5, 32'd10, 32'd0);
    step(10);
    key(FEED);
    chk("both_werr", 32'(bus.werr_o), 32'd1);
    chk("both_ovif", 32'(bus.ovif_o), 32'd1);
    chk("both_state", 32'(bus.state_o), 32'd2);

    // Valid feed on the timeout tick, then rst_i mid-pulse
    do_reset();
    cfg(1'b1, 20'd2, 32'd5, 32'd0, 32'd0);
    step(10);
    key(FEED);
    chk("race_no_ovif", 32'(bus.ovif_o), 32'd0);
    chk("race_cnt0", bus.cnt_o, 32'd0);
    chk("race_state", 32'(bus.state_o), 32'd1);
    step(10);
    chk("race_timeout", 32'(bus.rst_o), 32'd1);
    step(4);
    chk("race_pulse5", 32'(bus.rst_o), 32'd1);
    do_reset();
    chk("midrst_rsto", 32'(bus.rst_o), 32'd0);
    chk("midrst_state", 32'(bus.state_o), 32'd0);
    chk("midrst_flags", 32'({bus.werr_o, bus.ewif_o, bus.ovif_o}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
